// File: rtl/mem_addr_pkg.sv
// rtl/mem_addr_pkg.sv - shared encodings for the memory address generator
//
// Purpose: pc_sel update codes, the access FSM state type and the
// mem_sel constants used by mem_addr_gen and pc_next_calc.
// Ports: none (package).
package mem_addr_pkg;

  localparam logic [2:0] PC_HOLD = 3'b000;
  localparam logic [2:0] PC_INC  = 3'b001;
  localparam logic [2:0] PC_DEC  = 3'b010;
  localparam logic [2:0] PC_LOAD = 3'b011;
  localparam logic [2:0] PC_REL  = 3'b100;

  localparam logic MEM_SEL_PC  = 1'b0;
  localparam logic MEM_SEL_ALU = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next program counter
//
// Purpose: computes the next PC from the current PC, a pc_sel code and
// the ALU value. All arithmetic wraps modulo 2^XLEN. Codes 101..111 hold.
// Ports:
//   pc       in  XLEN  current program counter
//   pc_sel   in  3     update code (hold/inc/dec/load/relative)
//   alu_out  in  XLEN  load target or two's-complement relative offset
//   next_pc  out XLEN  resulting program counter
module pc_next_calc
  import mem_addr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  always_comb begin
    next_pc = pc;
    case (pc_sel)
      PC_INC:  next_pc = pc + STEP;
      PC_DEC:  next_pc = pc - STEP;
      PC_LOAD: next_pc = alu_out;
      PC_REL:  next_pc = pc + alu_out;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/mem_addr_gen.sv
// rtl/mem_addr_gen.sv - PC holder and memory address select with handshake
//
// Purpose: holds the PC, presents either PC (fetch) or alu_out (data) as
// the memory address and keeps it stable until mem_ready. The PC update
// requested with a fetch is applied when that fetch completes.
// Optional: MEM_ADDR_ALIGN_CHECK_EN rejects misaligned requests with a
// one-cycle misaligned pulse; otherwise misaligned is tied to 0.
// Ports:
//   clk        in  1     core clock
//   rst        in  1     asynchronous active-low reset
//   pc_sel     in  3     PC update code applied on fetch completion
//   mem_sel    in  1     0 = fetch at PC, 1 = data access at alu_out
//   req_valid  in  1     new access request
//   mem_ready  in  1     memory accepts the current address
//   alu_out    in  XLEN  data address or jump target/offset
//   addr       out XLEN  memory address
//   addr_valid out 1     addr is presented to memory
//   pc         out XLEN  registered program counter
//   busy       out 1     access outstanding
//   misaligned out 1     alignment fault pulse
module mem_addr_gen
  import mem_addr_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      pc_sel,
  input  logic            mem_sel,
  input  logic            req_valid,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] addr,
  output logic            addr_valid,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            misaligned
);

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic            addr_valid_q;
  logic            busy_q;
  logic            lat_mem_sel;
  logic [2:0]      lat_pc_sel;
  logic [XLEN-1:0] lat_alu;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_upd;
  logic [XLEN-1:0] cand_addr;
  logic            bad;

  pc_next_calc #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_pc_next_calc (
    .pc      (pc_q),
    .pc_sel  (lat_pc_sel),
    .alu_out (lat_alu),
    .next_pc (next_pc)
  );

  // PC after the outstanding access completes; data accesses leave it alone.
  assign pc_upd = (lat_mem_sel == MEM_SEL_PC) ? next_pc : pc_q;

  // A back-to-back fetch issued at completion must see the updated PC.
  assign cand_addr = (mem_sel == MEM_SEL_ALU) ? alu_out :
                     ((state == ST_WAIT) ? pc_upd : pc_q);

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_STEP - 1);

  logic accept;
  logic misaligned_q;

  assign accept = req_valid && ((state == ST_IDLE) || mem_ready);
  assign bad    = |(cand_addr & ALIGN_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= accept && bad;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign bad        = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      lat_mem_sel  <= MEM_SEL_PC;
      lat_pc_sel   <= PC_HOLD;
      lat_alu      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // addr is updated even on a rejected request for trap reporting.
            addr_q      <= cand_addr;
            lat_mem_sel <= mem_sel;
            lat_pc_sel  <= pc_sel;
            lat_alu     <= alu_out;
            if (!bad) begin
              addr_valid_q <= 1'b1;
              busy_q       <= 1'b1;
              state        <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            pc_q <= pc_upd;
            if (req_valid) begin
              addr_q      <= cand_addr;
              lat_mem_sel <= mem_sel;
              lat_pc_sel  <= pc_sel;
              lat_alu     <= alu_out;
              if (bad) begin
                addr_valid_q <= 1'b0;
                busy_q       <= 1'b0;
                state        <= ST_IDLE;
              end
            end else begin
              addr_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign pc         = pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_addr_gen.sv
// tb/tb_mem_addr_gen.sv - self-checking bench for mem_addr_gen
module tb_mem_addr_gen;

  logic        clk;
  logic        rst;
  logic [2:0]  pc_sel;
  logic        mem_sel;
  logic        req_valid;
  logic        mem_ready;
  logic [31:0] alu_out;
  logic [31:0] addr;
  logic        addr_valid;
  logic [31:0] pc;
  logic        busy;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  mem_addr_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100),
    .PC_STEP      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .mem_sel    (mem_sel),
    .req_valid  (req_valid),
    .mem_ready  (mem_ready),
    .alu_out    (alu_out),
    .addr       (addr),
    .addr_valid (addr_valid),
    .pc         (pc),
    .busy       (busy),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        ms;
    logic [2:0]  ps;
    logic        rdy;
    logic [31:0] alu;
    logic [31:0] e_addr;
    logic        e_av;
    logic        e_busy;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic rv, input logic ms, input logic [2:0] ps,
                              input logic rdy, input logic [31:0] alu,
                              input logic [31:0] e_addr, input logic e_av,
                              input logic e_busy, input logic [31:0] e_pc);
    vec_t v;
    v.rv = rv; v.ms = ms; v.ps = ps; v.rdy = rdy; v.alu = alu;
    v.e_addr = e_addr; v.e_av = e_av; v.e_busy = e_busy; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic ms, input logic [2:0] ps,
                       input logic rdy, input logic [31:0] alu);
    req_valid = rv; mem_sel = ms; pc_sel = ps; mem_ready = rdy; alu_out = alu;
  endtask

  initial begin
    vec_t e;
    // {req, mem_sel, pc_sel, ready, alu} -> {addr, addr_valid, busy, pc}
    vecs[0]  = mk(0, 0, 3'b000, 0, 32'h0,        32'h0,        0, 0, 32'h100);
    vecs[1]  = mk(1, 0, 3'b001, 1, 32'h0,        32'h100,      1, 1, 32'h100);
    vecs[2]  = mk(0, 0, 3'b000, 1, 32'h0,        32'h100,      0, 0, 32'h104);
    vecs[3]  = mk(1, 1, 3'b000, 0, 32'h2000,     32'h2000,     1, 1, 32'h104);
    vecs[4]  = mk(1, 0, 3'b001, 0, 32'h3000,     32'h2000,     1, 1, 32'h104);
    vecs[5]  = mk(1, 0, 3'b001, 0, 32'h3000,     32'h2000,     1, 1, 32'h104);
    vecs[6]  = mk(1, 1, 3'b011, 0, 32'h3000,     32'h2000,     1, 1, 32'h104);
    vecs[7]  = mk(0, 0, 3'b001, 0, 32'h3000,     32'h2000,     1, 1, 32'h104);
    vecs[8]  = mk(1, 1, 3'b100, 0, 32'h3000,     32'h2000,     1, 1, 32'h104);
    vecs[9]  = mk(0, 0, 3'b001, 1, 32'h3000,     32'h2000,     0, 0, 32'h104);
    vecs[10] = mk(1, 0, 3'b001, 0, 32'h0,        32'h104,      1, 1, 32'h104);
    vecs[11] = mk(1, 0, 3'b001, 1, 32'h0,        32'h108,      1, 1, 32'h108);
    vecs[12] = mk(1, 0, 3'b001, 1, 32'h0,        32'h10C,      1, 1, 32'h10C);
    vecs[13] = mk(0, 0, 3'b000, 1, 32'h0,        32'h10C,      0, 0, 32'h110);
    vecs[14] = mk(1, 0, 3'b100, 0, 32'hFFFFFFF0, 32'h110,      1, 1, 32'h110);
    vecs[15] = mk(0, 0, 3'b000, 1, 32'h0,        32'h110,      0, 0, 32'h100);
    vecs[16] = mk(1, 0, 3'b100, 1, 32'hFFFFFFF8, 32'h100,      1, 1, 32'h100);
    vecs[17] = mk(0, 0, 3'b000, 1, 32'h0,        32'h100,      0, 0, 32'hF8);
    vecs[18] = mk(1, 0, 3'b011, 1, 32'hFFFFFFFC, 32'hF8,       1, 1, 32'hF8);
    vecs[19] = mk(1, 0, 3'b001, 1, 32'h0,        32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC);
    vecs[20] = mk(0, 0, 3'b000, 1, 32'h0,        32'hFFFFFFFC, 0, 0, 32'h0);
    vecs[21] = mk(1, 0, 3'b010, 1, 32'h0,        32'h0,        1, 1, 32'h0);
    vecs[22] = mk(0, 0, 3'b000, 1, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFC);
    vecs[23] = mk(1, 0, 3'b111, 1, 32'h0,        32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC);
    vecs[24] = mk(0, 0, 3'b000, 1, 32'h0,        32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC);

    rst = 1'b0;
    drive(0, 0, 3'b000, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h100);
    chk("rst_addr", addr, 32'h0);
    chk("rst_av", {31'h0, addr_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mis", {31'h0, misaligned}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].ms, vecs[i].ps, vecs[i].rdy, vecs[i].alu);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_addr", i), addr, e.e_addr);
      chk($sformatf("v%0d_av", i), {31'h0, addr_valid}, {31'h0, e.e_av});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, e.e_busy});
      chk($sformatf("v%0d_pc", i), pc, e.e_pc);
      chk($sformatf("v%0d_mis", i), {31'h0, misaligned}, 32'h0);
    end

    // Reset during an outstanding data access: immediate abort, no pc update.
    @(negedge clk);
    drive(1, 1, 3'b000, 0, 32'h2000);
    @(posedge clk);
    #1;
    chk("mid_busy_pre", {31'h0, busy}, 32'h1);
    chk("mid_addr_pre", addr, 32'h2000);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_av", {31'h0, addr_valid}, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_pc", pc, 32'h100);
    chk("mid_addr", addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 3'b001, 1, 32'h0);
    @(posedge clk);
    #1;
    chk("post_pc", pc, 32'h100);
    chk("post_av", {31'h0, addr_valid}, 32'h0);

`ifdef MEM_ADDR_ALIGN_CHECK_EN
    @(negedge clk);
    drive(1, 1, 3'b000, 0, 32'h2002);
    @(posedge clk);
    #1;
    chk("al_mis", {31'h0, misaligned}, 32'h1);
    chk("al_av", {31'h0, addr_valid}, 32'h0);
    chk("al_busy", {31'h0, busy}, 32'h0);
    chk("al_addr", addr, 32'h2002);
    chk("al_pc", pc, 32'h100);
    @(negedge clk);
    drive(0, 0, 3'b000, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("al_mis_end", {31'h0, misaligned}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_addr_gen.md
Name: mem_addr_gen

Overview:
- Parametrised successor to the core's PC/memory-address select stage.
- Holds the program counter and selects between PC (fetch) and ALU result (data access) as the memory address.
- Adds a request/ready handshake so the address stays stable until memory accepts it.
- Adds relative jumps, a configurable step and a configurable reset vector. Sits between control/ALU and the memory port.

Parameters:
- XLEN, 32, width of PC, ALU result and address.
- RESET_VECTOR, 0, PC value after reset.
- PC_STEP, 4, byte increment/decrement per step; power of two, at least 1.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; when rst=0 all state is forced to reset values immediately.
- pc_sel  in  3  PC update for a fetch:
  - 000 hold
  - 001 PC+PC_STEP
  - 010 PC-PC_STEP
  - 011 load alu_out
  - 100 PC+alu_out (relative)
  - 101..111 treated as hold
- mem_sel  in  1  0 = fetch at PC, 1 = data access at alu_out.
- req_valid  in  1  new access request.
- mem_ready  in  1  memory accepts the current address.
- alu_out  in  XLEN  ALU result: data address or jump target/offset.
- addr  out  XLEN  memory address.
- addr_valid  out  1  addr is presented to memory.
- pc  out  XLEN  current program counter.
- busy  out  1  access outstanding (state WAIT).
- misaligned  out  1  alignment fault pulse (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_VECTOR, addr=0, addr_valid=0, busy=0, misaligned=0, state=IDLE.
- States:
  - IDLE: no access outstanding.
  - WAIT: address presented, awaiting mem_ready.
- IDLE, req_valid=1 on a clock edge:
  - Register addr = mem_sel ? alu_out : pc.
  - Latch mem_sel, pc_sel and alu_out.
  - Set addr_valid=1 and busy=1; go to WAIT.
  - Latency is 1 cycle from request to addr_valid.
- IDLE, req_valid=0: nothing changes.
- mem_ready is ignored in IDLE.
- WAIT, mem_ready=0:
  - addr, addr_valid and latched fields are held stable.
  - Inputs pc_sel, mem_sel, alu_out and req_valid are ignored.
- WAIT, mem_ready=1 (completion):
  - If latched mem_sel=0, pc <= next_pc(pc, latched pc_sel, latched alu_out).
  - If latched mem_sel=1, pc is unchanged.
- Completion with req_valid=0: addr_valid=0, busy=0, go to IDLE. addr keeps its last value.
- Completion with req_valid=1 (back-to-back):
  - The new request is latched on the same edge and the block stays in WAIT with addr_valid=1.
  - A new fetch address uses the updated pc (next_pc), not the old one.
- Arithmetic is unsigned modulo 2^XLEN; wrap-around is silent.
  - Example: 0xFFFFFFFC+4 = 0x00000000; 0-4 = 0xFFFFFFFC.
  - alu_out in relative mode is two's-complement, so a negative offset moves backward.
- Reset asserted mid-access: the access is aborted and all outputs return to reset values. No completion is recorded and pc is not updated.
- The pc output always shows the registered PC, never next_pc.

Optional Feature:
- Macro: MEM_ADDR_ALIGN_CHECK_EN.
- Defined:
  - On request acceptance in IDLE, if the candidate address bits [log2(PC_STEP)-1:0] are nonzero, the request is not issued.
  - addr_valid stays 0, state stays IDLE, pc is unchanged.
  - misaligned pulses 1 for one cycle; addr is still updated to the faulting address for trap reporting.
  - The same check applies to a back-to-back request at completion: the current access completes normally, then the block goes to IDLE with a misaligned pulse.
- Undefined:
  - misaligned is tied to 0.
  - Addresses are issued unmodified, regardless of alignment.

Decomposition:
- Package mem_addr_pkg:
  - pc_sel encodings (PC_HOLD, PC_INC, PC_DEC, PC_LOAD, PC_REL).
  - State enum (ST_IDLE, ST_WAIT).
  - MEM_SEL_PC and MEM_SEL_ALU constants.
- Sub-module pc_next_calc: combinational next_pc from pc, pc_sel, alu_out, PC_STEP.
  - Reused by the future branch predictor.
  - Top level keeps the FSM and registers.

Test Plan (XLEN=32, PC_STEP=4, RESET_VECTOR=0x00000100):
- Reset release:
  - rst=0 then 1 -> pc=0x100, addr_valid=0, busy=0.
  - req_valid=1, mem_sel=0, pc_sel=001, mem_ready=1 in the next cycle -> addr=0x100 for 1 cycle, then pc=0x104.
- Stall:
  - Data request mem_sel=1, alu_out=0x2000, mem_ready held 0 for 5 cycles while alu_out changes to 0x3000 -> addr stays 0x2000, busy=1 for the whole stall.
  - On mem_ready=1 the access completes and pc is unchanged.
- Back-to-back fetches with pc_sel=001, mem_ready=1 every cycle -> addr sequence 0x100, 0x104, 0x108, addr_valid continuously 1.
- Jumps and wrap:
  - pc_sel=100 with alu_out=-16 from pc=0x108 -> pc=0xF8.
  - pc_sel=011 with alu_out=0xFFFFFFFC, then pc_sel=001 -> pc wraps to 0x00000000.
- Reset mid-operation: rst=0 in WAIT with addr=0x2000 -> addr_valid=0, busy=0, pc=0x100 immediately (asynchronously); no pc update after release.
- With MEM_ADDR_ALIGN_CHECK_EN: request mem_sel=1, alu_out=0x2002 -> misaligned=1 for one cycle, addr_valid stays 0, state stays IDLE, pc unchanged.
